// File: rtl/vanity_pkg.sv
// Shared constants for the vanity key search datapath.
package vanity_pkg;

    // Width of the hash produced by the key generator and checked by vanity_compare.
    localparam int HASH_W          = 160;

    // Default width of the candidate key index (serial generator iteration counter).
    localparam int DEFAULT_IDX_W   = 64;

    // Cycles between a hash entering vanity_compare and its tx_match appearing.
    // The capture stage is exactly this deep.
    localparam int COMPARE_LATENCY = 1;

endpackage

// File: rtl/vanity_match_fifo.sv
// Generic show-ahead FIFO. Binary pointers carry one extra wrap bit, so equal
// pointers mean empty and MSB-only difference means full. A pop in the same
// cycle frees a slot for a push arriving while the FIFO is full.
module vanity_match_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);
    assign count_o = wrPtr_q - rdPtr_q;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    // Pointer next-state: clear wins over any push or pop in the same cycle.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + 1'b1;
            if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Pointer registers with asynchronous reset to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: data_o is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doPush && !clear_i) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vanity_match_capture.sv
// Pairs each candidate index with the comparator's delayed match flag, queues
// matching indices for the host, and counts matches lost to a full queue.
module vanity_match_capture
    import vanity_pkg::*;
#(
    parameter int IDX_W  = DEFAULT_IDX_W,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rx_reset_n,
    input  logic                     rx_clear,
    input  logic                     rx_valid,
    input  logic [IDX_W-1:0]         rx_index,
    input  logic                     rx_match,
    output logic                     tx_valid,
    output logic [IDX_W-1:0]         tx_index,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [DROP_W-1:0]        tx_dropped,
    output logic                     tx_overflow
);

    localparam int LAT = COMPARE_LATENCY;

    logic [LAT-1:0]            stageValid_q, stageValid_d;
    logic [LAT-1:0][IDX_W-1:0] stageIndex_q, stageIndex_d;
    logic [DROP_W-1:0]         dropCnt_q, dropCnt_d;
    logic                      overflow_q, overflow_d;
    logic                      push;
    logic                      drop;
    logic                      fifoFull;
    logic                      fifoEmpty;

    // Only a match whose index has travelled through the whole stage is real;
    // a match arriving with no paired index is ignored.
    assign push = stageValid_q[LAT-1] & rx_match;
    // A full FIFO only loses the entry when the host is not popping this cycle.
    assign drop = push & fifoFull & ~rx_ready & ~rx_clear;

    // Alignment shift: stage 0 captures the index, deeper stages just follow.
    always_comb begin
        stageValid_d    = stageValid_q;
        stageIndex_d    = stageIndex_q;
        stageValid_d[0] = rx_valid;
        if (rx_valid) stageIndex_d[0] = rx_index;
        for (int i = 1; i < LAT; i++) begin
            stageValid_d[i] = stageValid_q[i-1];
            stageIndex_d[i] = stageIndex_q[i-1];
        end
        if (rx_clear) stageValid_d = '0;
    end

    // Saturating drop counter and sticky overflow flag.
    always_comb begin
        dropCnt_d  = dropCnt_q;
        overflow_d = overflow_q;
        if (rx_clear) begin
            dropCnt_d  = '0;
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (dropCnt_q != '1) dropCnt_d = dropCnt_q + 1'b1;
        end
    end

    // Stage and drop bookkeeping registers, asynchronously reset.
    always_ff @(posedge clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            stageValid_q <= '0;
            stageIndex_q <= '0;
            dropCnt_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            stageValid_q <= stageValid_d;
            stageIndex_q <= stageIndex_d;
            dropCnt_q    <= dropCnt_d;
            overflow_q   <= overflow_d;
        end
    end

    vanity_match_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rx_reset_n),
        .clear_i (rx_clear),
        .push_i  (push),
        .data_i  (stageIndex_q[LAT-1]),
        .pop_i   (rx_ready),
        .data_o  (tx_index),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (tx_count)
    );

    assign tx_valid    = ~fifoEmpty;
    assign tx_dropped  = dropCnt_q;
    assign tx_overflow = overflow_q;

endmodule

// File: tb/tb_vanity_match_capture.sv
// Directed and scoreboarded bench for vanity_match_capture.
module tb_vanity_match_capture;

    localparam int IDX_W  = 64;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rx_reset_n;
    logic              rx_clear;
    logic              rx_valid;
    logic [IDX_W-1:0]  rx_index;
    logic              rx_match;
    logic              rx_ready;
    logic              tx_valid;
    logic [IDX_W-1:0]  tx_index;
    logic [3:0]        tx_count;
    logic [DROP_W-1:0] tx_dropped;
    logic              tx_overflow;

    int assertCount = 0;
    int failCount   = 0;

    logic [IDX_W-1:0] refQ [$];

    vanity_match_capture #(
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk         (clk),
        .rx_reset_n  (rx_reset_n),
        .rx_clear    (rx_clear),
        .rx_valid    (rx_valid),
        .rx_index    (rx_index),
        .rx_match    (rx_match),
        .tx_valid    (tx_valid),
        .tx_index    (tx_index),
        .rx_ready    (rx_ready),
        .tx_count    (tx_count),
        .tx_dropped  (tx_dropped),
        .tx_overflow (tx_overflow)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance past the next rising edge.
    task automatic applyStimulus(input logic v, input logic [63:0] idx, input logic m,
                                 input logic rdy, input logic clr);
        rx_valid = v;
        rx_index = idx;
        rx_match = m;
        rx_ready = rdy;
        rx_clear = clr;
        @(posedge clk);
        #1;
    endtask

    // Pipelined matches for indices first..first+n-1, no pops; stage ends empty.
    task automatic pushSequence(input logic [63:0] first, input int n);
        for (int k = 0; k <= n; k++) begin
            applyStimulus(k < n, first + 64'(k), k > 0, 1'b0, 1'b0);
        end
    endtask

    // Pop n entries, expecting consecutive indices starting at first.
    task automatic drainExpect(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("drain valid %0d", i), tx_valid, 1);
            checkOutput($sformatf("drain idx %0d", i), tx_index, first + 64'(i));
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain empty", tx_valid, 0);
        checkOutput("drain count", tx_count, 0);
    endtask

    initial begin
        logic             v, m, rdy, mV, popEff;
        logic [IDX_W-1:0] idx, mIdx, expIdx;
        int               sizeBefore, expDropped;

        rx_reset_n = 1'b0;
        rx_clear   = 1'b0;
        rx_valid   = 1'b0;
        rx_index   = '0;
        rx_match   = 1'b0;
        rx_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset tx_valid", tx_valid, 0);
        checkOutput("reset tx_index", tx_index, 0);
        checkOutput("reset tx_count", tx_count, 0);
        checkOutput("reset tx_dropped", tx_dropped, 0);
        checkOutput("reset tx_overflow", tx_overflow, 0);
        rx_reset_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] single match");
        applyStimulus(1'b1, 64'h1234, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 not yet valid", tx_valid, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1 valid", tx_valid, 1);
        checkOutput("t1 index", tx_index, 64'h1234);
        checkOutput("t1 count", tx_count, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 held", tx_valid, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1 popped", tx_valid, 0);
        checkOutput("t1 index after pop", tx_index, 0);

        $display("[TB] orphan match");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("t2 valid", tx_valid, 0);
        checkOutput("t2 count", tx_count, 0);

        $display("[TB] fill and overflow");
        pushSequence(64'd1, 10);
        checkOutput("t3 count", tx_count, 8);
        checkOutput("t3 dropped", tx_dropped, 2);
        checkOutput("t3 overflow", tx_overflow, 1);
        drainExpect(64'd1, 8);
        checkOutput("t3 dropped kept", tx_dropped, 2);

        $display("[TB] full with push and pop");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4 clear dropped", tx_dropped, 0);
        checkOutput("t4 clear overflow", tx_overflow, 0);
        pushSequence(64'd1, 8);
        checkOutput("t4 full count", tx_count, 8);
        applyStimulus(1'b1, 64'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4 count", tx_count, 8);
        checkOutput("t4 dropped", tx_dropped, 0);
        checkOutput("t4 overflow", tx_overflow, 0);
        drainExpect(64'd2, 8);

        $display("[TB] empty push with ready");
        applyStimulus(1'b1, 64'd77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("empty push count", tx_count, 1);
        drainExpect(64'd77, 1);

        $display("[TB] clear mid-stream");
        pushSequence(64'd1, 3);
        checkOutput("t5 queued", tx_count, 3);
        applyStimulus(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("t5 clear count", tx_count, 0);
        checkOutput("t5 clear valid", tx_valid, 0);
        checkOutput("t5 clear dropped", tx_dropped, 0);
        applyStimulus(1'b1, 64'h66, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5 pre-clear index discarded", tx_count, 0);

        $display("[TB] async reset mid-stream");
        pushSequence(64'd1, 10);
        checkOutput("t5 overflow before reset", tx_overflow, 1);
        #2;
        rx_reset_n = 1'b0;
        #1;
        checkOutput("t5 rst valid", tx_valid, 0);
        checkOutput("t5 rst index", tx_index, 0);
        checkOutput("t5 rst count", tx_count, 0);
        checkOutput("t5 rst dropped", tx_dropped, 0);
        checkOutput("t5 rst overflow", tx_overflow, 0);
        #1;
        rx_reset_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        pushSequence(64'h99, 1);
        checkOutput("t5 after reset index", tx_index, 64'h99);
        checkOutput("t5 after reset count", tx_count, 1);

        $display("[TB] wrap-around scoreboard");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        refQ.delete();
        mV         = 1'b0;
        mIdx       = '0;
        expDropped = 0;
        for (int c = 0; c < 200; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            idx = {$urandom, $urandom};
            m   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            sizeBefore = refQ.size();
            popEff     = rdy && (sizeBefore > 0);
            if (popEff) void'(refQ.pop_front());
            if (mV && m) begin
                if (sizeBefore < DEPTH || popEff) refQ.push_back(mIdx);
                else if (expDropped < 65535) expDropped++;
            end
            mV = v;
            if (v) mIdx = idx;
            applyStimulus(v, idx, m, rdy, 1'b0);
            expIdx = (refQ.size() > 0) ? refQ[0] : '0;
            checkOutput($sformatf("t6 count c%0d", c), tx_count, refQ.size());
            checkOutput($sformatf("t6 valid c%0d", c), tx_valid, refQ.size() > 0);
            checkOutput($sformatf("t6 index c%0d", c), tx_index, expIdx);
        end
        checkOutput("t6 dropped", tx_dropped, expDropped);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
